// File: rtl/gf2_poly_divider.sv
// Bit-serial carry-less (GF(2)[x]) long divider: 2N-bit dividend / N-bit divisor.
// A degree search on the divisor runs first, then one dividend bit is consumed per cycle, MSB first.
module gf2_poly_divider #(
  parameter int N = 409
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int W  = 2 * N;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    DEG,
    DIV,
    DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_dividend;
  logic [N-1:0]    r_divisor;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_degD;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_rem;
  logic [W-1:0]    r_quo;

  logic [N-1:0]    w_shiftRem;
  logic            w_qbit;
  logic [N-1:0]    w_nextRem;
  logic [W-1:0]    w_nextQuo;

  // r_dividend shifts left every DIV cycle, so its MSB is always the bit at index cnt.
  always_comb begin
    w_shiftRem = {r_rem[N-2:0], r_dividend[W-1]};
    w_qbit     = w_shiftRem[r_degD];
    w_nextRem  = w_qbit ? (w_shiftRem ^ r_divisor) : w_shiftRem;
    w_nextQuo  = {r_quo[W-2:0], w_qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_idx       <= '0;
      r_degD      <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_idx      <= IW'(N - 1);
            in_ready   <= 1'b0;
            r_state    <= DEG;
          end
        end

        DEG: begin
          if (r_divisor[r_idx]) begin
            r_degD  <= r_idx;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= CW'(W - 1);
            r_state <= DIV;
          end else if (r_idx == '0) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            out_valid   <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end

        // Remainder stays below degree deg_d, so dropping r_rem[N-1] on the shift loses nothing.
        DIV: begin
          r_rem      <= w_nextRem;
          r_quo      <= w_nextQuo;
          r_dividend <= {r_dividend[W-2:0], 1'b0};
          if (r_cnt == '0) begin
            quotient    <= w_nextQuo;
            remainder   <= w_nextRem;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Self-checking bench for gf2_poly_divider: directed and random jobs against a
// textbook polynomial long-division model, plus handshake and reset checks.
module tb_gf2_poly_divider;

  localparam int N       = 409;
  localparam int W       = 2 * N;
  localparam int MAXWAIT = 2000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gf2_poly_divider #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32 + 1; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  // Divisor with exactly the given degree and random lower coefficients.
  function automatic logic [N-1:0] randDivisor(input int deg);
    logic [N-1:0] one;
    logic [N-1:0] v;
    one = N'(1);
    v   = N'(randWide());
    return (v & ((one << deg) - one)) | (one << deg);
  endfunction

  function automatic logic [W-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) if (b[i]) p ^= W'(a) << i;
    return p;
  endfunction

  // Classic long division: cancel the leading term with a shifted divisor.
  function automatic void refDiv(input logic [W-1:0] a, input logic [N-1:0] b,
                                 output logic [W-1:0] q, output logic [N-1:0] r,
                                 output logic dz, output int lat);
    int deg;
    logic [W-1:0] rem;
    logic [W-1:0] bExt;
    deg = -1;
    for (int i = 0; i < N; i++) if (b[i]) deg = i;
    q  = '0;
    r  = '0;
    dz = 1'b0;
    if (deg < 0) begin
      dz  = 1'b1;
      lat = N;
      return;
    end
    rem  = a;
    bExt = W'(b);
    for (int i = W - 1; i >= deg; i--) begin
      if (rem[i]) begin
        rem ^= bExt << (i - deg);
        q[i - deg] = 1'b1;
      end
    end
    r   = rem[N-1:0];
    lat = (N - deg) + W;
  endfunction

  task automatic startJob(input logic [W-1:0] a, input logic [N-1:0] b, input string tag);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = randWide();
    divisor  = N'(randWide());
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < MAXWAIT);
  endtask

  task automatic checkOutput(input logic [W-1:0] a, input logic [N-1:0] b, input string tag,
                             input int lat, input int hold);
    logic [W-1:0] eq;
    logic [N-1:0] er;
    logic         edz;
    int           elat;
    refDiv(a, b, eq, er, edz, elat);
    check({tag, "_latency"}, W'(lat), W'(elat));
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, W'(remainder), W'(er));
    check({tag, "_div_by_zero"}, W'(div_by_zero), W'(edz));
    check({tag, "_hs_flags"}, W'({out_valid, in_ready}), W'(2'b10));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_flags"}, W'({out_valid, in_ready}), W'(2'b10));
      check({tag, "_hold_result"}, quotient ^ W'(remainder) ^ W'(div_by_zero),
            eq ^ W'(er) ^ W'(edz));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_release_flags"}, W'({out_valid, in_ready}), W'(2'b01));
    check({tag, "_retained_quotient"}, quotient, eq);
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [N-1:0] b,
                               input int hold, input string tag);
    int lat;
    startJob(a, b, tag);
    waitResult(lat);
    checkOutput(a, b, tag, lat, hold);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] fa;
    logic [N-1:0] fb;
    int           lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", W'({in_ready, out_valid, div_by_zero}), W'(3'b100));
    check("reset_quotient", quotient, '0);
    check("reset_remainder", W'(remainder), '0);
    rst = 1'b0;

    $display("[TB] small directed division with 20-cycle output stall");
    applyStimulus(W'(32'h1F), N'(3), 20, "small");
    check("small_const_q", quotient, W'(32'hA));
    check("small_const_r", W'(remainder), W'(32'h1));

    $display("[TB] top-degree divisor");
    a = '0;
    a[817] = 1'b1;
    a[5]   = 1'b1;
    b = '0;
    b[408] = 1'b1;
    applyStimulus(a, b, 0, "topdeg");
    a = '0;
    a[409] = 1'b1;
    check("topdeg_const_q", quotient, a);
    check("topdeg_const_r", W'(remainder), W'(32'h20));

    $display("[TB] divide by one");
    a = randWide();
    applyStimulus(a, N'(1), 0, "div_one");
    check("div_one_q_is_dividend", quotient, a);

    $display("[TB] product divided by a factor");
    fa = N'(randWide());
    fb = N'(randWide());
    if (fb == '0) fb = N'(1);
    applyStimulus(clmul(fa, fb), fb, 0, "product");
    check("product_q_is_factor", quotient, W'(fa));
    check("product_r_zero", W'(remainder), '0);

    $display("[TB] zero divisor then a normal job");
    applyStimulus(randWide(), '0, 3, "div_zero");
    check("div_zero_flag", W'(div_by_zero), W'(1));
    applyStimulus(randWide(), randDivisor($urandom_range(1, N - 1)), 0, "after_zero");

    $display("[TB] random divisors of random degree");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(randWide(), randDivisor($urandom_range(0, N - 1)), $urandom_range(0, 3),
                    $sformatf("rand%0d", k));
    end

    $display("[TB] reset during division");
    startJob(randWide(), N'(3), "midreset");
    repeat (408 + 300) @(posedge clk);
    @(negedge clk);
    check("midreset_busy", W'({out_valid, in_ready}), W'(2'b00));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_flags", W'({in_ready, out_valid, div_by_zero}), W'(3'b100));
    check("midreset_quotient", quotient, '0);
    check("midreset_remainder", W'(remainder), '0);
    a = randWide();
    b = randDivisor(200);
    startJob(a, b, "post_reset");
    waitResult(lat);
    checkOutput(a, b, "post_reset", lat, 0);
    check("post_reset_nominal_latency", W'(lat), W'((N - 200) + W));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
